// File: rtl/bsg_cordic_hyp_pkg.sv
// Shared types and constants for the iterative hyperbolic CORDIC engine:
// FSM states, repeat-iteration schedule and the 1/K_h start gains.
package bsg_cordic_hyp_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_iter = 2'd1,
        e_done = 2'd2
    } state_e;

    // Hyperbolic iterations that must be executed twice for convergence
    localparam int unsigned rep_k0_lp = 4;
    localparam int unsigned rep_k1_lp = 13;
    localparam int unsigned rep_k2_lp = 40;
    localparam int unsigned rep_k3_lp = 121;

    // 1/K_h at 14 fractional bits, with and without repeated iterations
    localparam int gain_frac_lp      = 14;
    localparam int gain_rep_q14_lp   = 19784;
    localparam int gain_norep_q14_lp = 19745;

    function automatic logic is_repeat_k(input int unsigned k);
        return (k == rep_k0_lp) || (k == rep_k1_lp) || (k == rep_k2_lp) || (k == rep_k3_lp);
    endfunction

    // Number of repeated iterations for a given base stage count
    function automatic int unsigned num_repeats(input int unsigned stages);
        int unsigned r;
        r = 0;
        if (rep_k0_lp <= stages) r++;
        if (rep_k1_lp <= stages) r++;
        if (rep_k2_lp <= stages) r++;
        if (rep_k3_lp <= stages) r++;
        return r;
    endfunction

    // Rescale a q14 gain constant to the datapath fraction width
    function automatic int gain_scaled(input int gain_q14, input int unsigned frac);
        if (frac >= 32'(gain_frac_lp))
            return gain_q14 <<< (frac - 32'(gain_frac_lp));
        else
            return gain_q14 >>> (32'(gain_frac_lp) - frac);
    endfunction

endpackage

// File: rtl/bsg_cordic_hyperbolic_atanh_rom.sv
// Combinational k -> atanh(2^-k) table, rounded to ang_frac_p bits with a 1 LSB floor.
module bsg_cordic_hyperbolic_atanh_rom #(
    parameter  int unsigned ang_width_p = 16,
    parameter  int unsigned ang_frac_p  = 14,
    parameter  int unsigned stages_p    = 16,
    localparam int unsigned k_width_lp  = $clog2(stages_p + 2)
) (
    input  logic [k_width_lp-1:0]  k_i,
    output logic [ang_width_p-1:0] atanh_o
);

    localparam int unsigned depth_lp = 1 << k_width_lp;

    // Series atanh(x) = sum x^(2n+1)/(2n+1), evaluated in q60 at elaboration
    function automatic logic [ang_width_p-1:0] atanh_entry(input int unsigned k);
        longint unsigned acc;
        longint unsigned q;
        int unsigned     e;
        acc = 64'd0;
        for (int unsigned n = 0; n < 32; n++) begin
            e = k * (2 * n + 1);
            if (e <= 60)
                acc += (64'd1 << (60 - e)) / 64'(2 * n + 1);
        end
        q = (acc + (64'd1 << (59 - ang_frac_p))) >> (60 - ang_frac_p);
        if (q == 64'd0)
            q = 64'd1;
        return ang_width_p'(q);
    endfunction

    logic [ang_width_p-1:0] rom [depth_lp];

    for (genvar i = 0; i < depth_lp; i++) begin : g_rom
        if (i == 0) begin : g_zero
            assign rom[i] = '0;
        end else begin : g_val
            localparam logic [ang_width_p-1:0] val_lp = atanh_entry(i);
            assign rom[i] = val_lp;
        end
    end

    assign atanh_o = rom[k_i];

endmodule

// File: rtl/bsg_cordic_hyperbolic_iter_ctrl.sv
// Iterative hyperbolic CORDIC: one shared micro-rotation, cosh/sinh via valid/yumi.
// BSG_CORDIC_HYP_REPEAT_EN enables the repeated iterations (k = 4, 13, 40, 121).
module bsg_cordic_hyperbolic_iter_ctrl
    import bsg_cordic_hyp_pkg::*;
#(
    parameter int unsigned ans_width_p = 16,
    parameter int unsigned ans_frac_p  = 14,
    parameter int unsigned ang_width_p = 16,
    parameter int unsigned ang_frac_p  = 14,
    parameter int unsigned stages_p    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [ang_width_p-1:0] ang_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [ans_width_p-1:0] cosh_o,
    output logic [ans_width_p-1:0] sinh_o,
    input  logic                   yumi_i
);

    localparam int unsigned k_width_lp = $clog2(stages_p + 2);

`ifdef BSG_CORDIC_HYP_REPEAT_EN
    localparam logic rep_en_lp  = 1'b1;
    localparam int   gain_q_lp  = gain_scaled(gain_rep_q14_lp, ans_frac_p);
`else
    localparam logic rep_en_lp  = 1'b0;
    localparam int   gain_q_lp  = gain_scaled(gain_norep_q14_lp, ans_frac_p);
`endif

    state_e state_r, state_n;

    logic signed [ans_width_p-1:0] x_r, y_r, x_shift, y_shift, x_n, y_n;
    logic signed [ang_width_p-1:0] z_r, z_n, atanh_k;
    logic [k_width_lp-1:0]         k_r;
    logic                          rep_r;
    logic                          do_rep;
    logic                          last_iter;

    bsg_cordic_hyperbolic_atanh_rom #(
        .ang_width_p (ang_width_p),
        .ang_frac_p  (ang_frac_p),
        .stages_p    (stages_p)
    ) atanh_rom (
        .k_i     (k_r),
        .atanh_o (atanh_k)
    );

    assign do_rep    = rep_en_lp && is_repeat_k(32'(k_r)) && !rep_r;
    assign last_iter = (k_r == k_width_lp'(stages_p)) && !do_rep;

    // Micro-rotation; both x and y updates use the pre-rotation values
    always_comb begin
        x_shift = x_r >>> k_r;
        y_shift = y_r >>> k_r;
        if (z_r[ang_width_p-1]) begin
            x_n = x_r - y_shift;
            y_n = y_r - x_shift;
            z_n = z_r + atanh_k;
        end else begin
            x_n = x_r + y_shift;
            y_n = y_r + x_shift;
            z_n = z_r - atanh_k;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            state_r <= e_idle;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle:  if (v_i)       state_n = e_iter;
            e_iter:  if (last_iter) state_n = e_done;
            e_done:  if (yumi_i)    state_n = e_idle;
            default:                state_n = e_idle;
        endcase
    end

    always_comb begin
        ready_o = (state_r == e_idle);
        v_o     = (state_r == e_done);
        cosh_o  = x_r;
        sinh_o  = y_r;
    end

    // Datapath and iteration schedule registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            k_r   <= k_width_lp'(1);
            rep_r <= 1'b0;
        end else begin
            unique case (state_r)
                e_idle: if (v_i) begin
                    x_r   <= ans_width_p'(gain_q_lp);
                    y_r   <= '0;
                    z_r   <= ang_i;
                    k_r   <= k_width_lp'(1);
                    rep_r <= 1'b0;
                end
                e_iter: begin
                    x_r <= x_n;
                    y_r <= y_n;
                    z_r <= z_n;
                    if (do_rep) begin
                        rep_r <= 1'b1;
                    end else begin
                        rep_r <= 1'b0;
                        k_r   <= k_r + k_width_lp'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_cordic_hyperbolic_iter_ctrl.sv
// Scoreboard bench for the iterative hyperbolic CORDIC; stimulus pushes expected
// results, a monitor/consumer pops on v_o, drives yumi and checks stability.
module tb_bsg_cordic_hyperbolic_iter_ctrl;

`ifdef BSG_CORDIC_HYP_REPEAT_EN
    localparam int lat_lp = 18;
    localparam int tol_lp = 8;
`else
    localparam int lat_lp = 16;
    localparam int tol_lp = 16;
`endif

    typedef struct {
        int id;
        int exp_cosh;
        int exp_sinh;
        int exp_cycle;
        int yumi_dly;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v_i = 1'b0;
    logic [15:0] ang = '0;
    logic        ready;
    logic        v_o;
    logic [15:0] cosh_v;
    logic [15:0] sinh_v;
    logic        yumi = 1'b0;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    bsg_cordic_hyperbolic_iter_ctrl dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .ang_i     (ang),
        .ready_o   (ready),
        .v_o       (v_o),
        .cosh_o    (cosh_v),
        .sinh_o    (sinh_v),
        .yumi_i    (yumi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_tests++;
        if (act - exp > tol || exp - act > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Monitor and consumer
    initial begin
        exp_t cur;
        bit   seen;
        int   wcnt;
        int   cap_c, cap_s;
        seen = 0; wcnt = 0; cap_c = 0; cap_s = 0;
        cur = '{0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                yumi = 1'b0;
                seen = 0;
            end else if (v_o) begin
                if (!seen) begin
                    seen = 1;
                    wcnt = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_v_o", 1, 0, 0);
                        cur = '{-1, 0, 0, 0, 0};
                    end else begin
                        cur = sb.pop_front();
                        check($sformatf("cosh[%0d]", cur.id), int'($signed(cosh_v)), cur.exp_cosh, tol_lp);
                        check($sformatf("sinh[%0d]", cur.id), int'($signed(sinh_v)), cur.exp_sinh, tol_lp);
                        check($sformatf("latency[%0d]", cur.id), cyc, cur.exp_cycle, 0);
                    end
                    cap_c = int'($signed(cosh_v));
                    cap_s = int'($signed(sinh_v));
                end else begin
                    check($sformatf("cosh_stable[%0d]", cur.id), int'($signed(cosh_v)), cap_c, 0);
                    check($sformatf("sinh_stable[%0d]", cur.id), int'($signed(sinh_v)), cap_s, 0);
                end
                yumi = (wcnt == cur.yumi_dly);
                wcnt++;
            end else begin
                yumi = 1'b0;
                seen = 0;
            end
        end
    end

    // Called at a negedge: present angle, wait for idle, record expected result
    task automatic send(input int id, input logic [15:0] a, input int ec, input int es, input int dly);
        v_i = 1'b1;
        ang = a;
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        if (!ready) begin
            check("accept_timeout", 0, 1, 0);
        end else begin
            sb.push_back('{id, ec, es, cyc + lat_lp + 1, dly});
        end
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb.size() != 0 || !ready); i++) @(negedge clk);
        if (sb.size() != 0 || !ready) begin
            check("drain_timeout", sb.size(), 0, 0);
            sb.delete();
        end
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(ready), 1, 0);
        check("rst_v_o", int'(v_o), 0, 0);
        check("rst_cosh", int'($signed(cosh_v)), 0, 0);
        check("rst_sinh", int'($signed(sinh_v)), 0, 0);

`ifdef BSG_CORDIC_HYP_REPEAT_EN
        send(0, 16'h0000, 16384, 0, 0);
        drain();
`endif
        send(1, 16'd8192, 18475, 8538, 0);
        drain();
        send(2, 16'hE000, 18475, -8538, 1);
        drain();
        send(3, 16'd4096, 16899, 4139, 2);
        drain();

        // v_i held high across a delayed yumi; the second angle waits for idle
        v_i = 1'b1;
        ang = 16'd8192;
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        acc = cyc;
        sb.push_back('{4, 18475, 8538, acc + lat_lp + 1, 5});
        sb.push_back('{5, 18475, -8538, acc + lat_lp + 7 + lat_lp + 1, 0});
        @(negedge clk);
        ang = 16'hE000;
        for (int i = 1; i <= lat_lp + 7; i++) begin
            check($sformatf("ready_hold[%0d]", i), int'(ready), (i == lat_lp + 7) ? 1 : 0, 0);
            if (i < lat_lp + 7) @(negedge clk);
        end
        @(negedge clk);
        v_i = 1'b0;
        drain();

        // Reset during ITER cycle 7 discards the in-flight result
        v_i = 1'b1;
        ang = 16'd8192;
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        @(negedge clk);
        v_i = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_v_o", int'(v_o), 0, 0);
        check("midrst_cosh", int'($signed(cosh_v)), 0, 0);
        check("midrst_sinh", int'($signed(sinh_v)), 0, 0);
        check("midrst_ready", int'(ready), 1, 0);
        send(6, 16'd8192, 18475, 8538, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
